// File: rtl/fifo_byte_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_byte_reader_if
//   Bundles the FIFO read side and the SCSI byte side of fifo_byte_reader.
//   master : the environment (FIFO + SCSI engine) driving the reader
//   slave  : the fifo_byte_reader itself
// Signals
//   fifo_empty / fifo_data / fifo_rd : first-word fall-through FIFO pop port
//   bo_init / load                   : programmable starting byte offset
//   flush                            : abort / end-of-transfer discard
//   byte_req / byte_ack / byte_out   : 4-phase byte handshake
//   uurs / umrs / lmrs / llrs        : one-hot byte-lane read strobes
//   valid_bytes / busy               : status of the held longword
// -----------------------------------------------------------------------------
interface fifo_byte_reader_if #(
    parameter int DW = 32,
    parameter int BW = 8
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd;
    logic [1:0]    bo_init;
    logic          load;
    logic          flush;
    logic          byte_req;
    logic          byte_ack;
    logic [BW-1:0] byte_out;
    logic          uurs;
    logic          umrs;
    logic          lmrs;
    logic          llrs;
    logic [2:0]    valid_bytes;
    logic          busy;

    modport master (
        output fifo_empty, fifo_data, bo_init, load, flush, byte_req,
        input  fifo_rd, byte_ack, byte_out, uurs, umrs, lmrs, llrs,
               valid_bytes, busy
    );

    modport slave (
        input  fifo_empty, fifo_data, bo_init, load, flush, byte_req,
        output fifo_rd, byte_ack, byte_out, uurs, umrs, lmrs, llrs,
               valid_bytes, busy
    );
endinterface

// File: rtl/fifo_byte_reader.sv
// -----------------------------------------------------------------------------
// fifo_byte_reader
//   Pops 32-bit longwords from the SDMAC FIFO and serialises them onto the
//   8-bit SCSI side, one byte per 4-phase REQ/ACK handshake, big-endian lane
//   order (byte pointer 0 = bits 31:24). A starting byte offset can be loaded
//   for misaligned transfers; flush discards the held word.
// Ports
//   clk_i : system clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : fifo_byte_reader_if.slave (FIFO pop port, byte handshake,
//           lane strobes, valid byte count, busy)
// -----------------------------------------------------------------------------
module fifo_byte_reader (
    input  logic               clk_i,
    input  logic               rst_i,
    fifo_byte_reader_if.slave  bus
);
    localparam int DW = 32;
    localparam int BW = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [DW-1:0] word_q, word_d;
    logic [BW-1:0] byte_q, byte_d;
    logic          ack_q, ack_d;
    logic [3:0]    strb_q, strb_d;
    logic [2:0]    vb_q, vb_d;
    logic          busy_q, busy_d;
    logic          fetch_s;

    // Big-endian lane select: pointer 0 picks the most significant byte.
    function automatic logic [BW-1:0] lane_sel(input logic [DW-1:0] w, input logic [1:0] p);
        logic [BW-1:0] r;
        case (p)
            2'd0:    r = w[31:24];
            2'd1:    r = w[23:16];
            2'd2:    r = w[15:8];
            2'd3:    r = w[7:0];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // One-hot {UU,UM,LM,LL} strobe for the lane under the pointer; silent when no word is held.
    function automatic logic [3:0] strobe_dec(input state_t s, input logic [1:0] p);
        logic [3:0] r;
        if (s == ST_EMPTY) begin
            r = 4'b0000;
        end else begin
            r = 4'b1000 >> p;
        end
        return r;
    endfunction

    // Bytes still to be delivered from the held word.
    function automatic logic [2:0] valid_cnt(input state_t s, input logic [1:0] p);
        logic [2:0] r;
        if (s == ST_EMPTY) begin
            r = 3'd0;
        end else begin
            r = 3'd4 - {1'b0, p};
        end
        return r;
    endfunction

    // Pop is combinational so the FIFO advances on the same edge the word is captured;
    // gated by reset so a word is never popped without being held.
    assign fetch_s = (state_q == ST_EMPTY) && !bus.fifo_empty && !bus.flush && !rst_i;

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        byte_d  = byte_q;
        ack_d   = ack_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
            ptr_d   = 2'd0;
            ack_d   = 1'b0;
        end else begin
            // A new offset is only accepted while no byte is in flight.
            if (bus.load && (state_q != ST_ACK)) begin
                ptr_d = bus.bo_init;
            end else begin
                ptr_d = ptr_q;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (fetch_s) begin
                        word_d  = bus.fifo_data;
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // A load cycle takes precedence; a still-high REQ is served next cycle.
                    if (bus.byte_req && !bus.load) begin
                        byte_d  = lane_sel(word_q, ptr_q);
                        ack_d   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_ACK: begin
                    if (!bus.byte_req) begin
                        ack_d   = 1'b0;
                        ptr_d   = ptr_q + 2'd1;
                        state_d = (ptr_q == 2'd3) ? ST_EMPTY : ST_FULL;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    ptr_d   = 2'd0;
                    ack_d   = 1'b0;
                end
            endcase
        end
        strb_d = strobe_dec(state_d, ptr_d);
        vb_d   = valid_cnt(state_d, ptr_d);
        busy_d = (state_d != ST_EMPTY);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            ptr_q   <= 2'd0;
            word_q  <= 32'd0;
            byte_q  <= 8'd0;
            ack_q   <= 1'b0;
            strb_q  <= 4'd0;
            vb_q    <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            ack_q   <= ack_d;
            strb_q  <= strb_d;
            vb_q    <= vb_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.fifo_rd     = fetch_s;
    assign bus.byte_ack    = ack_q;
    assign bus.byte_out    = byte_q;
    assign bus.uurs        = strb_q[3];
    assign bus.umrs        = strb_q[2];
    assign bus.lmrs        = strb_q[1];
    assign bus.llrs        = strb_q[0];
    assign bus.valid_bytes = vb_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_fifo_byte_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_byte_reader
//   Directed and randomized bench for fifo_byte_reader. A small array-based
//   FIFO feeds the DUT; a queue of pushed words plus a byte pointer forms the
//   reference for every byte, strobe and count.
// -----------------------------------------------------------------------------
module tb_fifo_byte_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_byte_reader_if bus ();

    fifo_byte_reader dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Bench-side FIFO
    logic [31:0] fifo_mem [0:255];
    int unsigned wr_idx = 0;
    int unsigned rd_idx = 0;
    int unsigned rd_cnt = 0;
    int unsigned rd_in_busy = 0;

    assign bus.fifo_empty = (rd_idx == wr_idx);
    assign bus.fifo_data  = fifo_mem[rd_idx[7:0]];

    // Pop the bench FIFO on each DUT pop strobe, and flag pops while a word is held.
    always @(posedge clk) begin
        if (bus.fifo_rd) begin
            rd_idx <= rd_idx + 1;
            rd_cnt <= rd_cnt + 1;
            if (bus.busy) rd_in_busy <= rd_in_busy + 1;
        end
    end

    // Reference model
    logic [31:0] exp_q [$];
    int          m_ptr = 0;
    int unsigned pushed = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_idx[7:0]] = w;
        wr_idx = wr_idx + 1;
        exp_q.push_back(w);
        pushed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete 4-phase byte transfer, checked against the reference.
    task automatic get_byte(input int hold);
        logic [31:0] w;
        int t;
        t = 0;
        while (!bus.busy && t < 50) begin
            tick();
            t++;
        end
        chk("busy_wait", {31'd0, bus.busy}, 32'd1);
        if (exp_q.size() == 0) begin
            chk("model_word", 32'd0, 32'd1);
            return;
        end
        w = exp_q[0];
        bus.byte_req = 1'b1;
        tick();
        chk("ack_rise", {31'd0, bus.byte_ack}, 32'd1);
        chk("byte_out", {24'd0, bus.byte_out}, (w >> (8 * (3 - m_ptr))) & 32'hFF);
        chk("strobes", {28'd0, bus.uurs, bus.umrs, bus.lmrs, bus.llrs}, 32'h8 >> m_ptr);
        chk("valid", {29'd0, bus.valid_bytes}, 32'(4 - m_ptr));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("ack_hold", {31'd0, bus.byte_ack}, 32'd1);
        end
        bus.byte_req = 1'b0;
        tick();
        chk("ack_fall", {31'd0, bus.byte_ack}, 32'd0);
        m_ptr = (m_ptr + 1) % 4;
        if (m_ptr == 0) void'(exp_q.pop_front());
        chk("busy_after", {31'd0, bus.busy}, (m_ptr != 0) ? 32'd1 : 32'd0);
        chk("valid_after", {29'd0, bus.valid_bytes}, (m_ptr != 0) ? 32'(4 - m_ptr) : 32'd0);
    endtask

    initial begin
        int off;
        int k;
        bus.bo_init  = 2'd0;
        bus.load     = 1'b0;
        bus.flush    = 1'b0;
        bus.byte_req = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ack", {31'd0, bus.byte_ack}, 32'd0);
        chk("rst_byte", {24'd0, bus.byte_out}, 32'd0);
        chk("rst_strb", {28'd0, bus.uurs, bus.umrs, bus.lmrs, bus.llrs}, 32'd0);
        chk("rst_valid", {29'd0, bus.valid_bytes}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_rd", {31'd0, bus.fifo_rd}, 32'd0);

        // 1: single aligned word, then a second fetch
        push_word(32'hA1B2C3D4);
        for (int i = 0; i < 4; i++) get_byte(0);
        chk("t1_rd_cnt", rd_cnt, 32'd1);
        push_word(32'h55667788);
        #1;
        chk("t1_rd2", {31'd0, bus.fifo_rd}, 32'd1);
        for (int i = 0; i < 4; i++) get_byte(1);
        chk("t1_rd_cnt2", rd_cnt, 32'd2);

        // 2: misaligned start at lane 2, next word back at lane 0
        bus.load = 1'b1;
        bus.bo_init = 2'd2;
        tick();
        bus.load = 1'b0;
        m_ptr = 2;
        push_word(32'h11223344);
        get_byte(0);
        get_byte(0);
        chk("t2_busy", {31'd0, bus.busy}, 32'd0);
        push_word(32'h99AABBCC);
        for (int i = 0; i < 4; i++) get_byte(0);

        // 3: flush during the second byte's handshake
        push_word(32'hDEADBEEF);
        push_word(32'hCAFEF00D);
        get_byte(0);
        bus.byte_req = 1'b1;
        tick();
        chk("t3_ack", {31'd0, bus.byte_ack}, 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("t3_no_rd", {31'd0, bus.fifo_rd}, 32'd0);
        tick();
        bus.flush = 1'b0;
        bus.byte_req = 1'b0;
        chk("t3_ack0", {31'd0, bus.byte_ack}, 32'd0);
        chk("t3_busy0", {31'd0, bus.busy}, 32'd0);
        void'(exp_q.pop_front());
        m_ptr = 0;
        for (int i = 0; i < 4; i++) get_byte(0);

        // 4: FIFO empty held, then one word arrives
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_no_rd", {31'd0, bus.fifo_rd}, 32'd0);
            chk("t4_idle", {31'd0, bus.busy}, 32'd0);
        end
        push_word(32'h0BADF00D);
        #1;
        chk("t4_rd", {31'd0, bus.fifo_rd}, 32'd1);
        tick();
        chk("t4_busy", {31'd0, bus.busy}, 32'd1);
        chk("t4_rd_off", {31'd0, bus.fifo_rd}, 32'd0);
        for (int i = 0; i < 4; i++) get_byte(0);

        // 5: reset mid-handshake with REQ staying high
        push_word(32'h12345678);
        get_byte(0);
        bus.byte_req = 1'b1;
        tick();
        chk("t5_ack", {31'd0, bus.byte_ack}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ack0", {31'd0, bus.byte_ack}, 32'd0);
        chk("t5_byte0", {24'd0, bus.byte_out}, 32'd0);
        chk("t5_strb0", {28'd0, bus.uurs, bus.umrs, bus.lmrs, bus.llrs}, 32'd0);
        chk("t5_valid0", {29'd0, bus.valid_bytes}, 32'd0);
        chk("t5_busy0", {31'd0, bus.busy}, 32'd0);
        void'(exp_q.pop_front());
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_ack", {31'd0, bus.byte_ack}, 32'd0);
        end
        push_word(32'h87654321);
        for (int i = 0; i < 4; i++) get_byte(0);

        // 6: back-to-back words
        k = int'(rd_cnt);
        push_word(32'h01020304);
        push_word(32'h05060708);
        for (int i = 0; i < 8; i++) get_byte(0);
        chk("t6_rd_pulses", rd_cnt - k, 32'd2);

        // Randomized: random offsets, word counts, values and REQ hold times
        for (int it = 0; it < 12; it++) begin
            off = int'($urandom_range(0, 3));
            if (off != 0) begin
                bus.load = 1'b1;
                bus.bo_init = 2'(off);
                tick();
                bus.load = 1'b0;
                m_ptr = off;
            end
            k = int'($urandom_range(1, 3));
            for (int j = 0; j < k; j++) push_word($urandom);
            while (exp_q.size() > 0) begin
                get_byte(int'($urandom_range(0, 2)));
                if ($urandom_range(0, 3) == 0) tick();
            end
        end

        tick();
        chk("total_rd", rd_cnt, pushed);
        chk("rd_while_busy", rd_in_busy, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
